// File: rtl/uart_boot_loader_pkg.sv
// uart_boot_loader_pkg: shared widths and loader state encoding
package uart_boot_loader_pkg;
  localparam int BYTE_WID = 8;
  localparam int DATA_WID = 32;
  typedef enum logic [1:0] {LEN, DATA, DONE, ERR} loader_state_t;
endpackage

// File: rtl/uart_boot_loader_word_assembler.sv
// word_assembler: packs little-endian bytes into 32-bit words and flags the completing byte
import uart_boot_loader_pkg::*;

module word_assembler (
  input  logic                clk,
  input  logic                rst,
  input  logic                i_clr,
  input  logic                i_valid,
  input  logic [BYTE_WID-1:0] i_byte,
  output logic [1:0]          o_bidx,
  output logic [DATA_WID-1:0] o_word,
  output logic                o_last
);
  logic [DATA_WID-BYTE_WID-1:0] r_sh;
  logic [1:0]                   r_bidx;
  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      r_sh   <= '0;
      r_bidx <= '0;
    end else if (i_clr) begin
      r_bidx <= '0;
    end else if (i_valid) begin
      r_sh   <= {i_byte, r_sh[DATA_WID-BYTE_WID-1:BYTE_WID]};
      r_bidx <= r_bidx + 2'd1;
    end
  // The completing byte is merged combinationally so the word is ready on the same edge.
  assign o_bidx = r_bidx;
  assign o_word = {i_byte, r_sh};
  assign o_last = i_valid && r_bidx == 2'd3;
endmodule

// File: rtl/uart_boot_loader.sv
// uart_boot_loader: loads a length-prefixed UART byte stream into memory port B, then releases the CPU
import uart_boot_loader_pkg::*;

module uart_boot_loader #(
  parameter logic [31:0] BASE_ADDR   = 32'h0000_0000,
  parameter int          MAX_WORDS   = 16384,
  parameter int          TIMEOUT_CYC = 50_000_000
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [7:0]  rx_byte,
  input  logic        rx_valid,
  input  logic        reload,
  output logic [31:0] uart_addr,
  output logic [31:0] uart_data,
  output logic        uart_we,
  output logic        uart_done,
  output logic        err,
  output logic [15:0] words_left
);
  localparam int TW = $clog2(TIMEOUT_CYC + 1);
  loader_state_t r_state;
  logic [31:0]   r_addr, r_data;
  logic          r_we, r_done, r_err;
  logic [15:0]   r_left;
  logic [TW-1:0] r_tcnt;
  logic          w_acc, w_last, w_tout;
  logic [1:0]    w_bidx;
  logic [31:0]   w_word;
  assign w_acc  = rx_valid && !reload && (r_state == LEN || (r_state == DATA && r_left != 16'd0));
  assign w_tout = r_tcnt == TW'(TIMEOUT_CYC - 1);
  word_assembler u_asm (
    .clk    (clk),
    .rst    (rst),
    .i_clr  (reload),
    .i_valid(w_acc),
    .i_byte (rx_byte),
    .o_bidx (w_bidx),
    .o_word (w_word),
    .o_last (w_last)
  );
  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      r_state <= LEN;
      r_addr  <= '0;
      r_data  <= '0;
      r_we    <= 1'b0;
      r_done  <= 1'b0;
      r_err   <= 1'b0;
      r_left  <= '0;
      r_tcnt  <= '0;
    end else if (reload) begin
      r_state <= LEN;
      r_we    <= 1'b0;
      r_done  <= 1'b0;
      r_err   <= 1'b0;
      r_left  <= '0;
      r_tcnt  <= '0;
    end else begin
      r_we <= 1'b0;
      case (r_state)
        LEN:
          if (w_acc) begin
            r_tcnt <= '0;
            if (w_last) begin
              if (w_word == 32'd0) begin
                r_state <= DONE;
                r_done  <= 1'b1;
              end else if (w_word > 32'(MAX_WORDS)) begin
                r_state <= ERR;
                r_err   <= 1'b1;
              end else begin
                r_state <= DATA;
                r_left  <= w_word[15:0];
                r_addr  <= BASE_ADDR - 32'd4;
              end
            end
          end else if (w_bidx != 2'd0) begin
            if (w_tout) begin
              r_state <= ERR;
              r_err   <= 1'b1;
            end else r_tcnt <= r_tcnt + 1'b1;
          end
        // Completion is seen one cycle after the final write so done never overlaps a write.
        DATA:
          if (r_left == 16'd0) begin
            r_state <= DONE;
            r_done  <= 1'b1;
          end else if (w_acc) begin
            r_tcnt <= '0;
            if (w_last) begin
              r_data <= w_word;
              r_addr <= r_addr + 32'd4;
              r_left <= r_left - 16'd1;
              r_we   <= 1'b1;
            end
          end else if (w_tout) begin
            r_state <= ERR;
            r_err   <= 1'b1;
          end else r_tcnt <= r_tcnt + 1'b1;
        default: ;
      endcase
    end
  assign uart_addr  = r_addr;
  assign uart_data  = r_data;
  assign uart_we    = r_we;
  assign uart_done  = r_done;
  assign err        = r_err;
  assign words_left = r_left;
endmodule

// File: tb/tb_uart_boot_loader.sv
// tb_uart_boot_loader: directed frames with hand-computed writes, timeouts, errors and resets
module tb_uart_boot_loader;
  localparam logic [31:0] BASE = 32'h0000_1000;
  logic        clk, rst, rx_valid, reload;
  logic [7:0]  rx_byte;
  logic [31:0] uart_addr, uart_data;
  logic        uart_we, uart_done, err;
  logic [15:0] words_left;
  int          vec, miss, we_cnt, we_done, base;
  logic [31:0] wa [64];
  logic [31:0] wd [64];

  uart_boot_loader #(.BASE_ADDR(BASE), .MAX_WORDS(16384), .TIMEOUT_CYC(16)) dut (
    .clk       (clk),
    .rst       (rst),
    .rx_byte   (rx_byte),
    .rx_valid  (rx_valid),
    .reload    (reload),
    .uart_addr (uart_addr),
    .uart_data (uart_data),
    .uart_we   (uart_we),
    .uart_done (uart_done),
    .err       (err),
    .words_left(words_left)
  );

  always #5 clk = ~clk;

  always @(negedge clk)
    if (uart_we) begin
      if (we_cnt < 64) begin
        wa[we_cnt] = uart_addr;
        wd[we_cnt] = uart_data;
      end
      we_cnt++;
      if (uart_done) we_done++;
    end

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    vec++;
    if (got !== exp) begin
      miss++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  task automatic tick(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic send(input logic [7:0] b);
    rx_byte  = b;
    rx_valid = 1'b1;
    tick(1);
    rx_valid = 1'b0;
  endtask

  task automatic sendw(input logic [31:0] w);
    for (int i = 0; i < 4; i++) send(8'((w >> (8 * i)) & 32'hff));
  endtask

  task automatic do_reload();
    reload = 1'b1;
    tick(1);
    reload = 1'b0;
  endtask

  initial begin
    clk = 0; rst = 1; reload = 0; rx_valid = 0; rx_byte = 0;
    vec = 0; miss = 0; we_cnt = 0; we_done = 0;
    #3;
    chk("rst_addr", uart_addr, 32'h0);
    chk("rst_data", uart_data, 32'h0);
    chk("rst_flags", {29'd0, uart_we, uart_done, err}, 32'h0);
    chk("rst_left", 32'(words_left), 32'h0);
    tick(2);
    rst = 0;
    sendw(32'd1);
    chk("t1_hdr_left", 32'(words_left), 32'd1);
    chk("t1_hdr_addr", uart_addr, BASE - 32'd4);
    sendw(32'h12345678);
    chk("t1_we", 32'(uart_we), 32'd1);
    chk("t1_addr", uart_addr, BASE);
    chk("t1_data", uart_data, 32'h12345678);
    chk("t1_done_early", 32'(uart_done), 32'd0);
    chk("t1_left", 32'(words_left), 32'd0);
    tick(1);
    chk("t1_done", {30'd0, uart_we, uart_done}, 32'd1);
    do_reload();
    chk("t2_reload_done", 32'(uart_done), 32'd0);
    base = we_cnt;
    sendw(32'd3);
    for (int i = 1; i <= 12; i++) send(8'(i));
    chk("t2_last_we", {30'd0, uart_we, uart_done}, 32'd2);
    tick(1);
    chk("t2_done", {30'd0, uart_we, uart_done}, 32'd1);
    chk("t2_count", 32'(we_cnt - base), 32'd3);
    chk("t2_a0", wa[base], BASE);
    chk("t2_a1", wa[base + 1], BASE + 32'd4);
    chk("t2_a2", wa[base + 2], BASE + 32'd8);
    chk("t2_d0", wd[base], 32'h04030201);
    chk("t2_d1", wd[base + 1], 32'h08070605);
    chk("t2_d2", wd[base + 2], 32'h0C0B0A09);
    reload = 1'b1; rx_valid = 1'b1; rx_byte = 8'hAA;
    tick(1);
    reload = 1'b0; rx_valid = 1'b0;
    chk("t3_reload_clr", {29'd0, uart_done, err, 1'b0} | 32'(words_left), 32'd0);
    base = we_cnt;
    sendw(32'd0);
    chk("t3_zero_done", 32'(uart_done), 32'd1);
    chk("t3_zero_nowe", 32'(we_cnt - base), 32'd0);
    do_reload();
    sendw(32'd1);
    sendw(32'hDEADBEEF);
    chk("t3_reload_addr", uart_addr, BASE);
    chk("t3_reload_data", uart_data, 32'hDEADBEEF);
    do_reload();
    base = we_cnt;
    sendw(32'd16385);
    chk("t4_err", {30'd0, err, uart_done}, 32'd2);
    sendw(32'h55667788);
    tick(2);
    chk("t4_nowe", 32'(we_cnt - base), 32'd0);
    chk("t4_sticky", 32'(err), 32'd1);
    do_reload();
    chk("t4_reload_err", 32'(err), 32'd0);
    tick(20);
    chk("t5_len_idle", 32'(err), 32'd0);
    sendw(32'd2);
    send(8'hAA);
    send(8'hBB);
    tick(15);
    chk("t5_tout_15", 32'(err), 32'd0);
    tick(1);
    chk("t5_tout_16", 32'(err), 32'd1);
    do_reload();
    sendw(32'd2);
    send(8'h01);
    tick(15);
    send(8'h02);
    chk("t5_gap_ok", 32'(err), 32'd0);
    send(8'h03);
    send(8'h04);
    chk("t5_gap_word", {uart_data[30:0], uart_we}, {31'h04030201, 1'b1});
    chk("t5_gap_left", 32'(words_left), 32'd1);
    do_reload();
    sendw(32'd1);
    send(8'h11);
    send(8'h22);
    base = we_cnt;
    #2 rst = 1'b1;
    #1;
    chk("t6_rst_addr", uart_addr, 32'h0);
    chk("t6_rst_data", uart_data, 32'h0);
    chk("t6_rst_flags", {13'd0, uart_we, uart_done, err, words_left}, 32'h0);
    tick(3);
    rst = 1'b0;
    send(8'h33);
    send(8'h44);
    tick(2);
    chk("t6_no_we", 32'(we_cnt - base), 32'd0);
    chk("we_with_done", 32'(we_done), 32'd0);
    $display("== %0d vectors applied, %0d miscompares ==", vec, miss);
    $finish;
  end
endmodule
